// File: rtl/demux_stream_router_pkg.sv
// Shared constants for the 1-to-4 stream router: channel count, select width
// and symbolic channel indices.
package demux_stream_router_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;

endpackage

// File: rtl/demux_stream_router_out_slot.sv
// One-word output holding register with valid/ready handshake.
// A load on the same cycle as a drain replaces the word without a bubble.
module demux_stream_router_out_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] data_in,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          free
);

    logic          valid_reg;
    logic          valid_next;
    logic [DW-1:0] data_reg;
    logic [DW-1:0] data_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
        end
    end

    // Load wins over drain; data is left untouched on a plain drain.
    always_comb begin
        valid_next = valid_reg;
        data_next  = data_reg;
        if (load) begin
            valid_next = 1'b1;
            data_next  = data_in;
        end else if (valid_reg && ready) begin
            valid_next = 1'b0;
        end
    end

    always_comb begin
        valid = valid_reg;
        data  = data_reg;
        free  = ~valid_reg | ready;
    end

endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-4 stream router with per-channel enable masking and
// saturating delivery/drop statistics counters.
module demux_stream_router
    import demux_stream_router_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DW-1:0]     in_data,
    input  logic [NCH-1:0]    ch_en,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*DW-1:0] out_data,
    input  logic              cnt_clr,
    output logic [NCH*CW-1:0] ch_cnt,
    output logic [CW-1:0]     drop_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [NCH-1:0] slot_free;
    logic [NCH-1:0] load;
    logic           accept;
    logic           deliver;
    logic           drop;

    logic [CW-1:0]  ch_cnt_reg [NCH];
    logic [CW-1:0]  drop_cnt_reg;

    // A disabled destination always sinks the word so the producer never stalls on it.
    always_comb begin
        in_ready = ~ch_en[in_sel] | slot_free[in_sel];
        accept   = in_valid & in_ready;
        deliver  = accept & ch_en[in_sel];
        drop     = accept & ~ch_en[in_sel];
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign load[gi] = deliver & (in_sel == SEL_W'(gi));

            demux_stream_router_out_slot #(
                .DW(DW)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .load    (load[gi]),
                .data_in (in_data),
                .ready   (out_ready[gi]),
                .valid   (out_valid[gi]),
                .data    (out_data[gi*DW +: DW]),
                .free    (slot_free[gi])
            );

            // Clear takes priority over a same-cycle delivery.
            always_ff @(posedge clk) begin
                if (rst || cnt_clr) begin
                    ch_cnt_reg[gi] <= '0;
                end else if (load[gi] && ch_cnt_reg[gi] != CNT_MAX) begin
                    ch_cnt_reg[gi] <= ch_cnt_reg[gi] + 1'b1;
                end
            end

            assign ch_cnt[gi*CW +: CW] = ch_cnt_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            drop_cnt_reg <= '0;
        end else if (drop && drop_cnt_reg != CNT_MAX) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_reg;

endmodule
